// File: rtl/cond_pkg.sv
// Shared encodings for the condition-field decoder and the NZCV flag register.
package cond_pkg;

    // Condition field encodings, Instr[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition-field decoder: Cond x {N,Z,C,V} -> pass/fail.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;
    logic ge;

    assign n  = flags_i[FLAG_N];
    assign z  = flags_i[FLAG_Z];
    assign c  = flags_i[FLAG_C];
    assign v  = flags_i[FLAG_V];
    assign ge = ~(n ^ v);

    // Decode the condition; the NV encoding never passes so no X can leak out.
    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = ge;
            COND_LT: cond_ex_o = ~ge;
            COND_GT: cond_ex_o = ~z & ge;
            COND_LE: cond_ex_o = z | ~ge;
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Architectural NZCV flag register plus condition gating of the FSM write strobes.
module cond_logic
    import cond_pkg::*;
#(
    parameter int unsigned FLAG_W = 4,
    parameter int unsigned COND_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COND_W-1:0] Cond,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              NextPC,
    input  logic              RegW,
    input  logic              MemW,
    output logic              PCWrite,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic [FLAG_W-1:0] Flags,
    output logic              CondEx
);

    logic [FLAG_W-1:0] flags_d, flags_q;
    logic              cond_ex_delayed_q;

    cond_check u_cond_check (
        .cond_i    (Cond),
        .flags_i   (flags_q),
        .cond_ex_o (CondEx)
    );

    // Each flag half updates only when requested and the instruction's condition passes.
    always_comb begin
        flags_d = flags_q;
        if (FlagW[1] && CondEx) begin
            flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
        end
        if (FlagW[0] && CondEx) begin
            flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
        end
    end

    // Flag register and the decode-time condition result carried into later FSM states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q           <= '0;
            cond_ex_delayed_q <= 1'b0;
        end else begin
            flags_q           <= flags_d;
            cond_ex_delayed_q <= CondEx;
        end
    end

    assign Flags = flags_q;

    // Fetch (NextPC) always advances the PC regardless of the condition.
    always_comb begin
        PCWrite  = (PCS & cond_ex_delayed_q) | NextPC;
        RegWrite = RegW & cond_ex_delayed_q;
        MemWrite = MemW & cond_ex_delayed_q;
    end

endmodule

// File: tb/tb_cond_logic.sv
// Directed scoreboard bench for cond_logic.
module tb_cond_logic;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, NextPC, RegW, MemW;
    logic       PCWrite, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;

    always #5 clk = ~clk;

    cond_logic dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags),
        .CondEx   (CondEx)
    );

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t       sbq[$];
    int         n_total = 0;
    int         n_pass  = 0;
    logic [3:0] m_flags;
    logic       m_ced;

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected {Flags, CondEx, PCWrite, RegWrite, MemWrite} from the model state
    function automatic logic [7:0] model_out();
        logic cex;
        cex = ref_cond(Cond, m_flags);
        return {m_flags, cex, (PCS & m_ced) | NextPC, RegW & m_ced, MemW & m_ced};
    endfunction

    task automatic chk1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic pop_check();
        exp_t e;
        e = sbq.pop_front();
        chk1(e.tag, {Flags, CondEx, PCWrite, RegWrite, MemWrite}, e.exp);
    endtask

    task automatic check_now(input string tag);
        sbq.push_back('{tag, model_out()});
        pop_check();
    endtask

    // Advance the model across one rising edge, push the expectation, clock the DUT, compare.
    task automatic clk_step(input string tag);
        logic cex;
        cex = ref_cond(Cond, m_flags);
        if (reset) begin
            if (FlagW[1] && cex) m_flags[3:2] = ALUFlags[3:2];
            if (FlagW[0] && cex) m_flags[1:0] = ALUFlags[1:0];
            m_ced = cex;
        end
        sbq.push_back('{tag, model_out()});
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic load_flags(input logic [3:0] f);
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
        clk_step("load_flags");
        FlagW = 2'b00;
    endtask

    initial begin
        m_flags = '0; m_ced = 1'b0;
        reset = 1'b0; Cond = 4'b1110; ALUFlags = 4'b1111; FlagW = 2'b11;
        PCS = 1'b0; NextPC = 1'b0; RegW = 1'b1; MemW = 1'b1;

        // Reset held across edges: nothing may update
        clk_step("reset_hold0");
        clk_step("reset_hold1");
        chk1("reset_strobes", {Flags, PCWrite, RegWrite, MemWrite}, 7'b0000000);

        // Release reset; AL passes immediately, strobes one cycle later
        reset = 1'b1; FlagW = 2'b00;
        #1;
        check_now("rel_condex");
        chk1("rel_condex_const", {7'b0, CondEx}, 8'd1);
        clk_step("rel_regw");
        chk1("rel_regw_const", {7'b0, RegWrite}, 8'd1);
        RegW = 1'b0; MemW = 1'b0;

        // Split flag write
        Cond = 4'b1110; ALUFlags = 4'b1111; FlagW = 2'b10;
        clk_step("split_nz");
        chk1("split_nz_const", {4'b0, Flags}, 8'b0000_1100);
        ALUFlags = 4'b0011; FlagW = 2'b01;
        clk_step("split_cv");
        chk1("split_cv_const", {4'b0, Flags}, 8'b0000_1111);

        // Failed condition blocks flag write and strobes
        load_flags(4'b0100);
        Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b0000; RegW = 1'b1;
        #1;
        check_now("block_condex");
        clk_step("block_step");
        chk1("block_const", {Flags, RegWrite}, 5'b0100_0);
        RegW = 1'b0; FlagW = 2'b00;

        // Full Cond x Flags sweep
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c);
                #1;
                check_now($sformatf("sweep_f%0d_c%0d", f, c));
                if (c == 15) chk1("nv_never", {7'b0, CondEx}, 8'd0);
            end
            clk_step("sweep_resync");
        end

        // Spot checks
        load_flags(4'b1001);
        Cond = 4'b1010; #1;
        chk1("spot_ge", {7'b0, CondEx}, 8'd1);
        load_flags(4'b0000);
        Cond = 4'b1100; #1;
        chk1("spot_gt", {7'b0, CondEx}, 8'd1);

        // PC strobe latency with Flags=0000
        PCS = 1'b1; Cond = 4'b1110;
        clk_step("pc_after_al");
        chk1("pc_after_al_const", {7'b0, PCWrite}, 8'd1);
        Cond = 4'b0000;
        clk_step("pc_after_eq");
        chk1("pc_after_eq_const", {7'b0, PCWrite}, 8'd0);
        NextPC = 1'b1; #1;
        check_now("pc_nextpc");
        chk1("pc_nextpc_const", {7'b0, PCWrite}, 8'd1);
        NextPC = 1'b0; PCS = 1'b0;

        // Async reset mid-operation
        load_flags(4'b1111);
        MemW = 1'b1; Cond = 4'b1110;
        clk_step("pre_async");
        chk1("pre_async_const", {Flags, MemWrite}, 5'b1111_1);
        #2;
        reset = 1'b0;
        m_flags = '0; m_ced = 1'b0;
        #1;
        check_now("async_reset");
        chk1("async_reset_const", {Flags, MemWrite}, 5'b0000_0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
